// File: rtl/matrix_pkg.sv
// Shared types, output range and the requantization helper for the
// matrix-vector accelerator's quantized datapath stages.
package matrix_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } wb_state_t;

    localparam int QMIN = -128;
    localparam int QMAX = 127;

    localparam logic signed [33:0] QMIN_EXT = 34'(QMIN);
    localparam logic signed [33:0] QMAX_EXT = 34'(QMAX);

    // Round-half-up, arithmetic shift, zero-point offset, saturate to int8.
    function automatic logic [7:0] requant(
        input logic signed [33:0] value,
        input logic        [4:0]  shift,
        input logic        [7:0]  zero_point
    );
        logic signed [33:0] w_rnd;
        logic signed [33:0] w_t;
        logic        [7:0]  w_res;
        w_rnd = 34'sd0;
        if (shift != 5'd0) begin
            w_rnd = 34'sd1 <<< (shift - 5'd1);
        end else begin
            w_rnd = 34'sd0;
        end
        w_t = value + w_rnd;
        w_t = w_t >>> shift;
        w_t = w_t + $signed({{26{zero_point[7]}}, zero_point});
        if (w_t > QMAX_EXT) begin
            w_res = 8'h7F;
        end else if (w_t < QMIN_EXT) begin
            w_res = 8'h80;
        end else begin
            w_res = w_t[7:0];
        end
        return w_res;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered head, full and empty flags.
// A push on a full FIFO is accepted only when a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic             o_full,
    output logic             o_empty,
    output logic [WIDTH-1:0] o_head
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             r_full;
    logic             r_empty;
    logic [WIDTH-1:0] r_head;

    logic             w_pop_ok;
    logic             w_push_ok;
    logic [CW-1:0]    w_count_next;
    logic [AW-1:0]    w_rd_ptr_inc;
    logic [WIDTH-1:0] w_head_next;

    assign w_pop_ok     = i_pop && !r_empty;
    assign w_push_ok    = i_push && (!r_full || w_pop_ok);
    assign w_count_next = r_count + CW'(w_push_ok) - CW'(w_pop_ok);
    assign w_rd_ptr_inc = r_rd_ptr + AW'(1);

    // Next head: the entry behind the popped one, or the incoming word when
    // it lands in an empty (or just-emptied) FIFO.
    always_comb begin
        w_head_next = r_head;
        if (w_pop_ok) begin
            if (r_count == CW'(1)) begin
                w_head_next = i_data;
            end else begin
                w_head_next = r_mem[w_rd_ptr_inc];
            end
        end else if (r_empty && w_push_ok) begin
            w_head_next = i_data;
        end else begin
            w_head_next = r_head;
        end
    end

    // Storage array write port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointers, occupancy, flags and head register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
            r_head   <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= w_rd_ptr_inc;
            end
            r_count <= w_count_next;
            r_full  <= (w_count_next == CW'(DEPTH));
            r_empty <= (w_count_next == CW'(0));
            r_head  <= w_head_next;
        end
    end

    assign o_full  = r_full;
    assign o_empty = r_empty;
    assign o_head  = r_head;

endmodule

// File: rtl/result_writeback.sv
// Drain stage: captures accumulator results, requantizes them to int8, buffers
// them and writes them to consecutive memory addresses, then pulses done_o.
module result_writeback
    import matrix_pkg::*;
#(
    parameter int          ACC_W            = 32,
    parameter int          ADDR_SIZE        = 10,
    parameter int          FIFO_DEPTH       = 16,
    parameter logic [15:0] RESULT_BASE_ADDR = 16'h0200
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 read_i,
    input  logic [ACC_W-1:0]     acc_i,
    input  logic [7:0]           column_size_i,
    input  logic [4:0]           shift_i,
    input  logic [7:0]           zero_point_i,
    output logic [ADDR_SIZE-1:0] mem_addr_o,
    output logic [7:0]           mem_data_o,
    output logic                 mem_we_o,
    input  logic                 mem_ready_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 overflow_o
);

    localparam logic [ADDR_SIZE-1:0] BASE_ADDR = RESULT_BASE_ADDR[ADDR_SIZE-1:0];

    wb_state_t             r_state;
    wb_state_t             w_state_next;
    logic [7:0]            r_target;
    logic [7:0]            r_wr_target;
    logic [7:0]            r_cap_cnt;
    logic [7:0]            r_wr_cnt;
    logic                  r_q_valid;
    logic [7:0]            r_q_data;
    logic [ADDR_SIZE-1:0]  r_addr;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_overflow;

    logic                  w_start;
    logic                  w_capture;
    logic                  w_pop;
    logic                  w_drop;
    logic                  w_full;
    logic                  w_empty;
    logic [7:0]            w_head;
    logic [7:0]            w_target_start;
    logic [7:0]            w_wr_cnt_next;
    logic [7:0]            w_wr_target_next;
    logic signed [33:0]    w_acc_ext;

    assign w_start          = (r_state == IDLE) && read_i;
    assign w_capture        = w_start || ((r_state == DRAIN) && read_i && (r_cap_cnt < r_target));
    assign w_pop            = !w_empty && mem_ready_i;
    // A dropped sample never produces a write, so it shrinks the write target.
    assign w_drop           = r_q_valid && w_full && !w_pop;
    assign w_target_start   = (column_size_i == 8'd0) ? 8'd1 : column_size_i;
    assign w_wr_cnt_next    = r_wr_cnt + {7'd0, w_pop};
    assign w_wr_target_next = r_wr_target - {7'd0, w_drop};
    assign w_acc_ext        = $signed({{(34 - ACC_W){acc_i[ACC_W-1]}}, acc_i});

    // Next-state decode; DONE is entered on the edge that accepts the last write.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (read_i) begin
                    w_state_next = DRAIN;
                end else begin
                    w_state_next = IDLE;
                end
            end
            DRAIN: begin
                if (w_wr_cnt_next == w_wr_target_next) begin
                    w_state_next = DONE;
                end else begin
                    w_state_next = DRAIN;
                end
            end
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // State register with registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_busy  <= (w_state_next != IDLE);
            r_done  <= (w_state_next == DONE);
        end
    end

    // Requantize stage: one register between capture and FIFO push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q_valid <= 1'b0;
            r_q_data  <= 8'd0;
        end else begin
            r_q_valid <= w_capture;
            if (w_capture) begin
                r_q_data <= requant(w_acc_ext, shift_i, zero_point_i);
            end else begin
                r_q_data <= r_q_data;
            end
        end
    end

    // Burst bookkeeping: counters, write address and sticky overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_target    <= 8'd0;
            r_wr_target <= 8'd0;
            r_cap_cnt   <= 8'd0;
            r_wr_cnt    <= 8'd0;
            r_addr      <= '0;
            r_overflow  <= 1'b0;
        end else if (w_start) begin
            r_target    <= w_target_start;
            r_wr_target <= w_target_start;
            r_cap_cnt   <= 8'd1;
            r_wr_cnt    <= 8'd0;
            r_addr      <= BASE_ADDR;
            r_overflow  <= 1'b0;
        end else begin
            if (w_capture) begin
                r_cap_cnt <= r_cap_cnt + 8'd1;
            end
            r_wr_cnt    <= w_wr_cnt_next;
            r_wr_target <= w_wr_target_next;
            if (w_pop) begin
                r_addr <= r_addr + ADDR_SIZE'(1);
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (r_q_valid),
        .i_data  (r_q_data),
        .i_pop   (w_pop),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_head  (w_head)
    );

    assign mem_we_o   = !w_empty;
    assign mem_data_o = w_head;
    assign mem_addr_o = r_addr;
    assign busy_o     = r_busy;
    assign done_o     = r_done;
    assign overflow_o = r_overflow;

endmodule

// File: doc/result_writeback.md
# result_writeback

Downstream drain stage of the matrix–vector accelerator. It captures one accumulator result per cycle from the systolic array while the controller's `read` strobe is high, requantizes each result to signed 8 bit (shift, round, zero-point, saturate), and buffers it in a small FIFO. It then writes the results to consecutive addresses of the shared data memory through a valid/ready write port, pulsing `done_o` once the whole result vector is committed.

## Interface
- `ACC_W`, 32: accumulator width from the array drain port
- `ADDR_SIZE`, 10: memory address width; matches the controller
- `FIFO_DEPTH`, 16: result buffer entries; power of two, at least 4
- `RESULT_BASE_ADDR`, 16'h0200: memory address of result element 0; truncated to `ADDR_SIZE`

Ports:
- `clk`  in  1  single clock
- `rst_n`  in  1  asynchronous, active-low reset
- `read_i`  in  1  controller `read` strobe; one valid result per high cycle
- `acc_i`  in  `ACC_W`  signed accumulator result; valid when `read_i`=1
- `column_size_i`  in  8  result count for this burst (controller column_size)
- `shift_i`  in  5  requantization right-shift amount
- `zero_point_i`  in  8  signed output zero point
- `mem_addr_o`  out  `ADDR_SIZE`  write address
- `mem_data_o`  out  8  requantized result
- `mem_we_o`  out  1  write request (valid)
- `mem_ready_i`  in  1  memory accepts the write this cycle
- `busy_o`  out  1  high from the first capture until `done_o`
- `done_o`  out  1  one-cycle pulse after the last write is accepted
- `overflow_o`  out  1  sticky flag: a sample was dropped because the FIFO was full

## Operation
- FSM states:
  - IDLE: waits for a burst. On `read_i`=1, it latches target = max(`column_size_i`,1), clears `cap_cnt` and `wr_cnt`, clears `overflow_o`, captures the first sample, and moves to DRAIN.
  - DRAIN: captures a sample on every `read_i`=1 cycle while `cap_cnt` < target; samples beyond target are ignored. When `wr_cnt` reaches target, it moves to DONE.
  - DONE: asserts `done_o` for one cycle, then returns to IDLE.
- Requantization, performed on a 34-bit signed intermediate:
  - Rounding: if `shift_i` > 0, add 1<<(`shift_i`-1).
  - Shift: arithmetic right shift by `shift_i`.
  - Offset: add the sign-extended `zero_point_i`.
  - Saturate to [-128, 127] and output as two's complement.
  - `shift_i` and `zero_point_i` are quasi-static during a burst.
- Writes:
  - `mem_we_o` = FIFO not empty.
  - `mem_data_o` = FIFO head.
  - `mem_addr_o` = `RESULT_BASE_ADDR` + `wr_cnt`, wrapping modulo 2^`ADDR_SIZE`.
  - The head pops and `wr_cnt` increments only when `mem_we_o` && `mem_ready_i`.
- FIFO full: a push is allowed on a full FIFO only if a pop happens in the same cycle. Otherwise the sample is dropped, `overflow_o` is set, and `cap_cnt` still increments, so the burst still terminates. The dropped slot produces no write; `wr_cnt` target is reduced by the number of dropped samples.
- `busy_o` = state ≠ IDLE.
- Reset values: all outputs 0, FIFO empty, counters 0, state IDLE.
- Reset asserted mid-burst: the FIFO is flushed and pending writes are abandoned, with no `done_o`.

## Timing
- Capture-to-FIFO latency: the requantize stage is one register. A sample present at edge t enters the FIFO at edge t+1.
- Write latency: the earliest `mem_we_o` for that sample is the cycle after t+1 (two cycles after capture). Memory sees an uninterrupted stream when `mem_ready_i` is held high.
- `mem_addr_o`/`mem_data_o` hold stable while `mem_we_o`=1 and `mem_ready_i`=0.
- `done_o` is high in the cycle after the edge that accepts the final write.
- A new burst can be accepted from IDLE, i.e. two cycles after the final accepted write. `read_i` asserted during DONE is ignored.
- Counters are 8 bit; target ≤ 255 and never wraps.

## Structure
- A shared package `matrix_pkg` holds:
  - `wb_state_t` enum {IDLE, DRAIN, DONE}
  - `QMIN`=-128 and `QMAX`=127
  - the `requant` function, also used by future quantized stages
- Sub-module `sync_fifo`: parameterized by width/depth, with `rst_n`, push/pop, full/empty, and registered head output. It is instantiated once, 8 wide, `FIFO_DEPTH` deep.

## Test plan
- column_size=4, shift=0, zp=0, acc={1,-2,127,-128}, `mem_ready_i`=1 → writes 0x01,0xFE,0x7F,0x80 to 0x200–0x203; first `mem_we_o` 2 cycles after the first `read_i`; `done_o` one cycle after the 4th write.
- shift=4, zp=10, acc={24, -24, 100000, -100000} → 12, 9, 127, -128 (round-half-up plus saturation).
- column_size=8, `mem_ready_i` low for 5 cycles mid-burst → address/data held stable; all 8 values written in order; `overflow_o`=0.
- FIFO_DEPTH=4, column_size=8, `mem_ready_i`=0 throughout capture → 4 samples kept; `overflow_o`=1; after ready rises, exactly 4 writes, then `done_o`.
- `rst_n` pulled low after 3 of 6 writes → all outputs 0 immediately; no `done_o`; the next burst restarts at 0x200.
- column_size=0 with a single `read_i` pulse → one write to 0x200, then `done_o`.
